// File: rtl/mmio_bus_pkg.sv
// mmio_bus_pkg: shared types and address decode for the memory/IO interconnect.
package mmio_bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MEM,
    ST_MEM_RD,
    ST_IO_WAIT,
    ST_RESP
  } state_t;

  // Upper address bits (above bit 9) that select the IO window on a 32-bit bus.
  localparam logic [21:0] IO_BASE_HI_DEF = 22'h3FFFFF;

  // Channel index field width; up to 8 channels.
  localparam int CH_IDX_W = 3;

  typedef struct packed {
    logic                is_io;
    logic [CH_IDX_W-1:0] ch;
    logic                misaligned;
    logic                bad_ch;
  } dec_t;

  // Classify one CPU address. The caller extracts the address fields so the
  // function stays independent of the bus widths.
  function automatic dec_t decode(input logic [1:0]          lo,
                                  input logic                hi_match,
                                  input logic [CH_IDX_W-1:0] ch,
                                  input int                  num_ch);
    dec_t d;
    d.is_io      = hi_match;
    d.ch         = ch;
    d.misaligned = (lo != 2'b00);
    d.bad_ch     = hi_match && (int'(ch) >= num_ch);
    return d;
  endfunction

endpackage

// File: rtl/mmio_bus_ctrl_if.sv
// mmio_bus_ctrl_if: CPU, data-memory and IO-channel signals of the interconnect.
// slave  = the controller's view; master = CPU, memory and peripherals.
interface mmio_bus_ctrl_if #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int NUM_CH    = 4,
  parameter int CH_SPAN_W = 4
);
  logic                     cpu_req;
  logic                     cpu_we;
  logic [ADDR_W-1:0]        cpu_addr;
  logic [DATA_W-1:0]        cpu_wdata;
  logic [DATA_W-1:0]        cpu_rdata;
  logic                     cpu_done;
  logic                     cpu_stall;
  logic                     cpu_err;

  logic                     mem_en;
  logic                     mem_we;
  logic [ADDR_W-1:0]        mem_addr;
  logic [DATA_W-1:0]        mem_wdata;
  logic [DATA_W-1:0]        mem_rdata;

  logic [NUM_CH-1:0]        io_valid;
  logic                     io_we;
  logic [CH_SPAN_W-1:0]     io_addr;
  logic [DATA_W-1:0]        io_wdata;
  logic [NUM_CH-1:0]        io_ready;
  logic [NUM_CH*DATA_W-1:0] io_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_done, cpu_stall, cpu_err,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata,
    output io_valid, io_we, io_addr, io_wdata,
    input  io_ready, io_rdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_done, cpu_stall, cpu_err,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata,
    input  io_valid, io_we, io_addr, io_wdata,
    output io_ready, io_rdata
  );
endinterface

// File: rtl/io_timeout_ctr.sv
// io_timeout_ctr: wait-cycle counter for IO handshakes. Held at zero by i_clr,
// counts while i_en, and flags the TIMEOUT-th enabled cycle as expired.
module io_timeout_ctr #(
  parameter int TIMEOUT = 255
) (
  input  logic clock,
  input  logic reset,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] r_cnt;

  // Saturating wait counter; cleared while no wait is in progress.
  always_ff @(posedge clock) begin
    if (reset || i_clr)
      r_cnt <= '0;
    else if (i_en && (r_cnt != CNT_W'(TIMEOUT)))
      r_cnt <= r_cnt + 1'b1;
  end

  // r_cnt holds the number of wait cycles already elapsed, so TIMEOUT-1 marks
  // the last cycle on which a ready can still be accepted.
  assign o_expired = i_en && (r_cnt == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mmio_bus_ctrl.sv
// mmio_bus_ctrl: CPU data-side interconnect to data memory and NUM_CH
// handshaked IO channels, with address decode, alignment check, IO timeout
// and a stall/done interface.
// Optional macro BUS_ERR_CAPTURE_EN adds err_clr / err_addr / err_sticky,
// which latch the address of the first failed access.
module mmio_bus_ctrl
  import mmio_bus_pkg::*;
#(
  parameter int                ADDR_W     = 32,
  parameter int                DATA_W     = 32,
  parameter int                NUM_CH     = 4,
  parameter int                CH_SPAN_W  = 4,
  parameter logic [ADDR_W-11:0] IO_BASE_HI = (ADDR_W-10)'(IO_BASE_HI_DEF),
  parameter int                TIMEOUT    = 255
) (
  input  logic             clock,
  input  logic             reset,
  mmio_bus_ctrl_if.slave   bus
`ifdef BUS_ERR_CAPTURE_EN
  ,
  input  logic             err_clr,
  output logic [ADDR_W-1:0] err_addr,
  output logic             err_sticky
`endif
);

  state_t              r_state, w_next;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_we;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W-1:0]   r_rdata;
  logic [CH_IDX_W-1:0] r_ch;
  logic                r_err;

  dec_t                w_dec;
  logic                w_dec_err;
  logic                w_sel_ready;
  logic [DATA_W-1:0]   w_sel_rdata;
  logic                w_expired;
  logic                w_waiting;
  logic                w_resp_err;

  // Decode the live CPU address; only used on the IDLE sampling cycle.
  always_comb begin
    w_dec     = decode(bus.cpu_addr[1:0],
                       bus.cpu_addr[ADDR_W-1:10] == IO_BASE_HI,
                       bus.cpu_addr[CH_SPAN_W +: CH_IDX_W],
                       NUM_CH);
    w_dec_err = w_dec.misaligned | w_dec.bad_ch;
  end

  // Pick the handshake and read data of the latched channel; other channels'
  // ready lines never reach the FSM.
  always_comb begin
    w_sel_ready = 1'b0;
    w_sel_rdata = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (r_ch == CH_IDX_W'(k)) begin
        w_sel_ready = bus.io_ready[k];
        w_sel_rdata = bus.io_rdata[k*DATA_W +: DATA_W];
      end
    end
  end

  assign w_waiting = (r_state == ST_IO_WAIT);

  io_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_tmo (
    .clock     (clock),
    .reset     (reset),
    .i_clr     (!w_waiting),
    .i_en      (w_waiting),
    .o_expired (w_expired)
  );

  // State register.
  always_ff @(posedge clock) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (bus.cpu_req) begin
          if (w_dec_err)        w_next = ST_RESP;
          else if (w_dec.is_io) w_next = ST_IO_WAIT;
          else                  w_next = ST_MEM;
        end
      end
      ST_MEM:     w_next = r_we ? ST_RESP : ST_MEM_RD;
      ST_MEM_RD:  w_next = ST_RESP;
      ST_IO_WAIT: if (w_sel_ready || w_expired) w_next = ST_RESP;
      ST_RESP:    w_next = ST_IDLE;
      default:    w_next = ST_IDLE;
    endcase
  end

  // Request latch, error decision and read-data capture. r_rdata only changes
  // on the edge into RESP, so cpu_rdata holds until the next completed read.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_addr  <= '0;
      r_we    <= 1'b0;
      r_wdata <= '0;
      r_ch    <= '0;
      r_err   <= 1'b0;
      r_rdata <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.cpu_req) begin
            r_addr  <= bus.cpu_addr;
            r_we    <= bus.cpu_we;
            r_wdata <= bus.cpu_wdata;
            r_ch    <= w_dec.ch;
            r_err   <= w_dec_err;
            if (w_dec_err && !bus.cpu_we) r_rdata <= '0;
          end
        end
        ST_MEM_RD: r_rdata <= bus.mem_rdata;
        ST_IO_WAIT: begin
          // A ready on the final allowed cycle still wins over the timeout.
          if (w_sel_ready) begin
            if (!r_we) r_rdata <= w_sel_rdata;
          end else if (w_expired) begin
            r_err <= 1'b1;
            if (!r_we) r_rdata <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  // One-hot channel strobe, held for the whole wait.
  always_comb begin
    bus.io_valid = '0;
    for (int k = 0; k < NUM_CH; k++)
      bus.io_valid[k] = w_waiting && (r_ch == CH_IDX_W'(k));
  end

  assign w_resp_err    = (r_state == ST_RESP) && r_err;

  assign bus.cpu_rdata = r_rdata;
  assign bus.cpu_done  = (r_state == ST_RESP);
  assign bus.cpu_err   = w_resp_err;
  assign bus.cpu_stall = ((r_state != ST_IDLE) && (r_state != ST_RESP)) ||
                         ((r_state == ST_IDLE) && bus.cpu_req);

  assign bus.mem_en    = (r_state == ST_MEM);
  assign bus.mem_we    = (r_state == ST_MEM) && r_we;
  assign bus.mem_addr  = r_addr;
  assign bus.mem_wdata = r_wdata;

  assign bus.io_we     = w_waiting && r_we;
  assign bus.io_addr   = r_addr[CH_SPAN_W-1:0];
  assign bus.io_wdata  = r_wdata;

`ifdef BUS_ERR_CAPTURE_EN
  logic [ADDR_W-1:0] r_err_addr;
  logic              r_err_sticky;

  // Keep the address of the first failed access until cleared.
  always_ff @(posedge clock) begin
    if (reset || err_clr) begin
      r_err_addr   <= '0;
      r_err_sticky <= 1'b0;
    end else if (w_resp_err && !r_err_sticky) begin
      r_err_addr   <= r_addr;
      r_err_sticky <= 1'b1;
    end
  end

  assign err_addr   = r_err_addr;
  assign err_sticky = r_err_sticky;
`endif

endmodule

// File: tb/tb_mmio_bus_ctrl.sv
// tb_mmio_bus_ctrl: directed + randomized bench for mmio_bus_ctrl. Expected
// behaviour comes from a per-transaction timeline (latency, strobe window,
// result) derived from the access rules, plus literal spot checks.
module tb_mmio_bus_ctrl;
  localparam int AW = 32, DW = 32, NCH = 4, SPW = 4, TMO = 8;

  logic clock = 1'b0;
  logic reset = 1'b1;

  mmio_bus_ctrl_if #(.ADDR_W(AW), .DATA_W(DW), .NUM_CH(NCH), .CH_SPAN_W(SPW)) bus ();

`ifdef BUS_ERR_CAPTURE_EN
  logic          err_clr = 1'b0;
  logic [AW-1:0] err_addr;
  logic          err_sticky;
`endif

  mmio_bus_ctrl #(.ADDR_W(AW), .DATA_W(DW), .NUM_CH(NCH), .CH_SPAN_W(SPW),
                  .TIMEOUT(TMO)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
`ifdef BUS_ERR_CAPTURE_EN
    ,
    .err_clr    (err_clr),
    .err_addr   (err_addr),
    .err_sticky (err_sticky)
`endif
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Model of the transaction in flight.
  bit          m_active = 1'b0;
  int          m_t0, m_done_rel, m_W, m_lat, m_kind;  // kind: 0 err, 1 mem, 2 io
  logic        m_we, m_err;
  logic [31:0] m_addr, m_wdata, m_rd;
  logic [31:0] m_hold = 32'h0;
  logic [2:0]  m_ch;
  int          vcnt;

  logic [31:0] m_mem   [logic [31:0]];
  logic [31:0] dev_mem [logic [31:0]];
  logic [31:0] iodata  [8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h cyc=%0d", nm, act, exp, cyc);
    end
  endtask

  initial forever begin
    @(posedge clock);
    cyc++;
  end

  // Data memory: 1-cycle read latency, garbage when no read is returning.
  initial begin : memdev
    bit          pv;
    logic [31:0] pd;
    bus.mem_rdata = '0;
    forever begin
      @(negedge clock);
      pv = 1'b0;
      pd = 32'h0;
      if (bus.mem_en === 1'b1) begin
        if (bus.mem_we) dev_mem[bus.mem_addr] = bus.mem_wdata;
        else begin
          pv = 1'b1;
          pd = dev_mem.exists(bus.mem_addr) ? dev_mem[bus.mem_addr] : 32'h0;
        end
      end
      @(posedge clock);
      #1;
      bus.mem_rdata = pv ? pd : $urandom;
    end
  end

  // Peripherals: selected channel raises ready on its m_lat-th (0-based)
  // strobe cycle; unselected ready bits toggle randomly.
  initial begin : iodev
    int vc;
    vc = 0;
    bus.io_ready = '0;
    forever begin
      @(posedge clock);
      #1;
      if (bus.io_valid != '0) vc++;
      else vc = 0;
      bus.io_ready = (NCH'($urandom) & ~bus.io_valid) |
                     (((bus.io_valid != '0) && (vc - 1 == m_lat)) ? bus.io_valid : '0);
    end
  end

  // Per-cycle comparison against the transaction timeline.
  initial begin : cmp
    int             rel;
    logic           e_done, e_err, e_stall, e_en, e_mwe;
    logic [NCH-1:0] e_v;
    @(posedge clock);
    forever begin
      @(negedge clock);
      e_done = 0; e_err = 0; e_stall = 0; e_en = 0; e_mwe = 0; e_v = '0;
      if (m_active) begin
        rel     = cyc - m_t0;
        e_stall = (rel < m_done_rel);
        e_done  = (rel == m_done_rel);
        e_err   = e_done && m_err;
        if (m_kind == 1 && rel == 1) begin
          e_en  = 1'b1;
          e_mwe = m_we;
        end
        if (m_kind == 2 && rel >= 1 && rel <= m_W) e_v = NCH'(1) << m_ch;
        if (e_done && !m_we) m_hold = m_rd;
      end
      chk("cpu_done",  32'(bus.cpu_done),  32'(e_done));
      chk("cpu_err",   32'(bus.cpu_err),   32'(e_err));
      chk("cpu_stall", 32'(bus.cpu_stall), 32'(e_stall));
      chk("mem_en",    32'(bus.mem_en),    32'(e_en));
      chk("mem_we",    32'(bus.mem_we),    32'(e_mwe));
      chk("io_valid",  32'(bus.io_valid),  32'(e_v));
      chk("cpu_rdata", bus.cpu_rdata,      m_hold);
      if (e_en) begin
        chk("mem_addr", bus.mem_addr, m_addr);
        if (m_we) chk("mem_wdata", bus.mem_wdata, m_wdata);
      end
      if (e_v != '0) begin
        vcnt++;
        chk("io_we",   32'(bus.io_we),   32'(m_we));
        chk("io_addr", 32'(bus.io_addr), 32'(m_addr[3:0]));
        if (m_we) chk("io_wdata", bus.io_wdata, m_wdata);
      end
    end
  end

  task automatic set_io();
    for (int k = 0; k < NCH; k++) bus.io_rdata[k*DW +: DW] = iodata[k];
  endtask

  // One CPU access. lat = ready position within the strobe window;
  // rst_at >= 0 asserts reset that many cycles after the request.
  task automatic do_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input int lat, input int rst_at,
                        output int lat_obs, output logic [31:0] rd_obs, output logic err_obs);
    logic mis, io;
    mis = (addr[1:0] != 2'b00);
    io  = (addr[31:10] == 22'h3FFFFF);
    m_we = we; m_addr = addr; m_wdata = wdata; m_ch = addr[6:4]; m_lat = lat;
    m_W = 0;
    if (mis || (io && int'(addr[6:4]) >= NCH)) begin
      m_kind = 0; m_done_rel = 1; m_err = 1'b1; m_rd = 32'h0;
    end else if (io) begin
      m_kind = 2;
      m_err  = (lat > TMO - 1);
      m_W    = m_err ? TMO : lat + 1;
      m_done_rel = m_W + 1;
      m_rd   = m_err ? 32'h0 : iodata[addr[6:4]];
    end else begin
      m_kind = 1; m_err = 1'b0;
      m_done_rel = we ? 2 : 3;
      m_rd = m_mem.exists(addr) ? m_mem[addr] : 32'h0;
      if (we && rst_at < 0) m_mem[addr] = wdata;
    end
    lat_obs = -1; rd_obs = 32'h0; err_obs = 1'b0;
    @(posedge clock);
    #1;
    bus.cpu_req = 1'b1; bus.cpu_we = we; bus.cpu_addr = addr; bus.cpu_wdata = wdata;
    vcnt = 0;
    m_t0 = cyc;
    m_active = 1'b1;
    if (rst_at >= 0) begin
      repeat (rst_at) begin
        @(posedge clock);
        #1;
      end
      reset = 1'b1;
      bus.cpu_req = 1'b0;
      @(posedge clock);
      #1;
      reset = 1'b0;
      m_active = 1'b0;
      m_hold = 32'h0;
      return;
    end
    for (int i = 0; i < 300; i++) begin
      @(negedge clock);
      if (bus.cpu_done === 1'b1) begin
        lat_obs = cyc - m_t0;
        rd_obs  = bus.cpu_rdata;
        err_obs = bus.cpu_err;
        break;
      end
    end
    if (lat_obs < 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL done_wait actual=none expected=cpu_done addr=%h", addr);
    end
    @(posedge clock);
    #1;
    bus.cpu_req = 1'b0;
    m_active = 1'b0;
  endtask

  initial begin : main
    int          l, sel, lat;
    logic [31:0] r, a, wd;
    logic        e, we;
    bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    for (int k = 0; k < 8; k++) iodata[k] = $urandom;
    set_io();
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;

    // Memory write then read-back.
    do_txn(1'b1, 32'h0000_0010, 32'hDEADBEEF, 0, -1, l, r, e);
    chk("wr_lat", 32'(l), 32'd2);
    chk("wr_err", 32'(e), 32'd0);
    do_txn(1'b0, 32'h0000_0010, 32'h0, 0, -1, l, r, e);
    chk("rd_lat", 32'(l), 32'd3);
    chk("rd_data", r, 32'hDEADBEEF);
    chk("rd_err", 32'(e), 32'd0);

    // IO read on channel 1, ready on the 6th strobe cycle.
    iodata[1] = 32'h0000_A5A5;
    set_io();
    do_txn(1'b0, 32'hFFFF_FC10, 32'h0, 5, -1, l, r, e);
    chk("io_lat", 32'(l), 32'd7);
    chk("io_data", r, 32'h0000_A5A5);
    chk("io_vcnt", 32'(vcnt), 32'd6);
    chk("io_err", 32'(e), 32'd0);

    // Channel 2 never answers.
    do_txn(1'b0, 32'hFFFF_FC20, 32'h0, 1000, -1, l, r, e);
    chk("to_lat", 32'(l), 32'd9);
    chk("to_err", 32'(e), 32'd1);
    chk("to_data", r, 32'h0);

    // Misaligned and out-of-range channel.
    do_txn(1'b0, 32'h0000_0013, 32'h0, 0, -1, l, r, e);
    chk("mis_lat", 32'(l), 32'd1);
    chk("mis_err", 32'(e), 32'd1);
    chk("mis_data", r, 32'h0);
    do_txn(1'b1, 32'hFFFF_FC70, 32'h1234_5678, 0, -1, l, r, e);
    chk("badch_lat", 32'(l), 32'd1);
    chk("badch_err", 32'(e), 32'd1);

    // Reset while waiting on channel 3, then a normal access.
    do_txn(1'b0, 32'hFFFF_FC30, 32'h0, 1000, 3, l, r, e);
    do_txn(1'b0, 32'h0000_0010, 32'h0, 0, -1, l, r, e);
    chk("post_rst_lat", 32'(l), 32'd3);
    chk("post_rst_data", r, 32'hDEADBEEF);

    // Randomized mix.
    for (int t = 0; t < 150; t++) begin
      sel = $urandom_range(0, 9);
      wd  = $urandom;
      lat = $urandom_range(0, 10);
      we  = 1'($urandom);
      a   = 32'h100 + 32'($urandom_range(0, 15)) * 4;
      if (sel <= 2) begin
        we = 1'b1;
        if ($urandom_range(0, 3) == 0) begin
          a = $urandom & 32'hFFFF_FFFC;
          if (a[31:10] == 22'h3FFFFF) a[31] = 1'b0;
        end
      end else if (sel <= 5) begin
        we = 1'b0;
      end else if (sel <= 8) begin
        a = {22'h3FFFFF, 6'($urandom), 4'($urandom) & 4'hC};
        if ($urandom_range(0, 3) == 0) begin
          for (int k = 0; k < NCH; k++) iodata[k] = $urandom;
          set_io();
        end
      end else begin
        a = ($urandom & 32'hFFFF_FFFC) | 32'($urandom_range(1, 3));
      end
      do_txn(we, a, wd, lat, -1, l, r, e);
    end

`ifdef BUS_ERR_CAPTURE_EN
    @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    m_hold = 32'h0;
    do_txn(1'b0, 32'h0000_0013, 32'h0, 0, -1, l, r, e);
    do_txn(1'b0, 32'h0000_0017, 32'h0, 0, -1, l, r, e);
    @(negedge clock);
    chk("err_addr", err_addr, 32'h0000_0013);
    chk("err_sticky", 32'(err_sticky), 32'd1);
    @(posedge clock);
    #1;
    err_clr = 1'b1;
    @(posedge clock);
    #1;
    err_clr = 1'b0;
    @(negedge clock);
    chk("err_cleared", 32'(err_sticky), 32'd0);
`endif

    repeat (2) @(posedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
